mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Iterative multi-cycle multiply/divide unit that sits beside the ALU in the single-issue core and drives the `Busy` stall input of the program counter. While an operation is in flight, `Busy` freezes the PC and the pipeline. In the single cycle after completion, the final results are presented for write-back and the PC advances. One FSM sequences a shared shift/add-subtract datapath for all four operations.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; iteration count per operation.

Ports:
- `CLK`, input, 1: clock, rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: decoder flags an MCycle instruction; held high by the stalled instruction.
- `MCycleOp`, input, 2: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- `Operand1`, input, `WIDTH`: multiplicand or dividend.
- `Operand2`, input, `WIDTH`: multiplier or divisor.
- `Result1`, output, `WIDTH`: product low half or quotient.
- `Result2`, output, `WIDTH`: product high half or remainder.
- `Busy`, output, 1: stall request to the PC and pipeline registers.

## Operation
- States are IDLE, COMPUTE and DONE; the reset state is IDLE.
- IDLE:
  - `Start`=1 → COMPUTE at the next edge.
  - On that edge, latch `MCycleOp`, |Operand1| and |Operand2| (absolute value only for signed ops), and the result sign bits.
  - Clear the iteration counter.
- COMPUTE:
  - One iteration per cycle; the counter runs 0..WIDTH-1.
  - After the iteration at count WIDTH-1 → DONE.
  - Operand, op and `Start` changes are ignored.
- DONE:
  - Load `Result1`/`Result2` with the sign-corrected values; return to IDLE.
  - `Start` is ignored in DONE, so the same instruction cannot retrigger.
- Multiply: shift-add over a 2·WIDTH accumulator.
  - Signed: negate the 2·WIDTH product if sign1≠sign2.
- Divide: restoring division over a WIDTH remainder and WIDTH quotient.
  - Signed: quotient negated if sign1≠sign2; remainder takes the dividend's sign.
- Divide by zero: `Result1` = all ones, `Result2` = Operand1 unmodified, for both signed and unsigned ops.
- Signed MIN/−1: `Result1` = MIN, `Result2` = 0. This falls out of the magnitude arithmetic and needs no special case.
- Result registers hold their value until the next DONE.
- All arithmetic is modulo 2^WIDTH per half; internal magnitudes are WIDTH bits unsigned, so |MIN| = 2^(WIDTH-1) is representable.

## Timing
- `Busy` = (IDLE ∧ `Start`) ∨ COMPUTE. It is combinational from `Start`, so the PC holds in the same cycle the instruction is decoded.
- Stall length is WIDTH+1 cycles: the Start cycle plus WIDTH COMPUTE cycles. `Busy`=0 in DONE.
- Results are valid from the DONE cycle onward; write-back samples them at the end of DONE.
- Back-to-back MCycle instructions: the next `Start` arrives in IDLE one cycle after DONE and restarts normally. There is no bubble beyond DONE.
- Reset:
  - `Reset_n`=0 forces IDLE, counter 0, `Result1`=`Result2`=0 and `Busy`=0 asynchronously, including mid-COMPUTE.
  - The first rising `CLK` after release with `Start`=1 begins a fresh operation.
- `Start` low mid-COMPUTE (e.g. flush) does not abort; the operation completes and the results are discarded by the pipeline.

## Structure
- Shared package `mcycle_pkg`:
  - op encodings `OP_SMUL`, `OP_UMUL`, `OP_SDIV`, `OP_UDIV`.
  - state enum `IDLE`/`COMPUTE`/`DONE`.
  - `CNT_W` = $clog2(WIDTH).
- Natural sub-module `mcycle_iter_dp`: the accumulator/remainder shift registers and one add-or-subtract step, controlled by an op and step-enable from the top-level FSM.
- Sign correction and the divide-by-zero override are done in the top level at DONE.

## Test plan
All cases use WIDTH=32.
- SMUL 7×6, `Start` held until `Busy` falls → `Busy` high exactly 33 cycles; in DONE `Result1`=42, `Result2`=0.
- SMUL −3×5 → `Result1`=0xFFFFFFF1, `Result2`=0xFFFFFFFF. UMUL 0xFFFFFFFF×2 → `Result1`=0xFFFFFFFE, `Result2`=0x00000001.
- SDIV −7/2 → `Result1`=0xFFFFFFFD, `Result2`=0xFFFFFFFF. UDIV 100/7 → 14, 2. SDIV 0x80000000/−1 → 0x80000000, 0.
- UDIV 10/0 and SDIV −10/0 → `Result1`=0xFFFFFFFF; `Result2`=10 and 0xFFFFFFF6 respectively.
- Drop `Reset_n` at COMPUTE cycle 10 → `Busy`=0 and results 0 immediately. After release, UMUL 3×4 → 12 after a full 33-cycle stall.
- Two consecutive MCycle ops (UMUL 2×3, then UDIV 9/3) → DONE for the first, then IDLE with `Busy` high again. Results are 6 then 3, with no retrigger in DONE.

Source files
------------

// File: rtl/mcycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_pkg
// Purpose  : Shared definitions for the multi-cycle multiply/divide unit:
//            operation encodings, FSM state encoding and counter sizing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mcycle_pkg;

    // MCycleOp encodings: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_SMUL = 2'b00;
    localparam logic [1:0] OP_UMUL = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;
    localparam logic [1:0] OP_UDIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        DONE    = 2'b10
    } state_t;

    // Iteration counter width for a given operand width (never below 1 bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Counter width for the core's standard 32-bit configuration.
    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/mcycle_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_unit_if
// Purpose  : Request/result bundle between the decoder/pipeline (master)
//            and the multi-cycle multiply/divide unit (slave).
// Ports    : Start, MCycleOp, Operand1, Operand2  (master -> slave)
//            Result1, Result2, Busy               (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy
    );
endinterface
`default_nettype wire

// File: rtl/mcycle_iter_dp.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_iter_dp
// Purpose  : Shared iterative datapath. r_hi/r_lo form the 2*WIDTH
//            multiply accumulator or the remainder/quotient pair; r_b holds
//            the multiplicand or divisor. One add-or-subtract per step.
// Ports    : CLK, Reset_n      clock, async active-low reset
//            i_load            load operands (r_hi cleared)
//            i_step            perform one iteration
//            i_is_div          1 = restoring-divide step, 0 = shift-add step
//            i_ld_lo, i_ld_b   multiplier/dividend and multiplicand/divisor
//            o_hi, o_lo        product high/low or remainder/quotient
// Revision : 1.0 - initial release
// ============================================================================
module mcycle_iter_dp #(
    parameter int WIDTH = 32
) (
    input  wire logic             CLK,
    input  wire logic             Reset_n,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic             i_is_div,
    input  wire logic [WIDTH-1:0] i_ld_lo,
    input  wire logic [WIDTH-1:0] i_ld_b,
    output logic      [WIDTH-1:0] o_hi,
    output logic      [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_opa;
    logic [WIDTH:0]   w_opb;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH:0]   w_add;
    logic             w_fits;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Single W+2 bit adder shared by both operations. For divide it computes
    // {rem, next dividend bit} - divisor; the top bit is the "no borrow" flag.
    always_comb begin
        w_opa  = i_is_div ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
        w_opb  = i_is_div ? ~{1'b0, r_b} : {1'b0, r_b};
        w_sum  = {1'b0, w_opa} + {1'b0, w_opb} + {{(WIDTH+1){1'b0}}, i_is_div};
        w_fits = w_sum[WIDTH+1];
        w_add  = r_lo[0] ? w_sum[WIDTH:0] : {1'b0, r_hi};
        if (i_is_div) begin
            // Partial remainder is always below the divisor, so the low
            // WIDTH bits of the difference are exact when it fits.
            w_hi_nxt = w_fits ? w_sum[WIDTH-1:0] : w_opa[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_fits};
        end else begin
            // Add multiplicand if multiplier LSB set, then shift the whole
            // accumulator (including carry) right by one.
            w_hi_nxt = w_add[WIDTH:1];
            w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_ld_lo;
            r_b  <= i_ld_b;
        end else if (i_step) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_unit
// Purpose  : Iterative multiply/divide unit beside the ALU. Stalls the PC via
//            Busy for WIDTH+1 cycles, then presents sign-corrected results in
//            the single DONE cycle and holds them until the next DONE.
// Ports    : CLK      clock, rising edge
//            Reset_n  asynchronous active-low reset
//            bus      mcycle_unit_if.slave: Start, MCycleOp, Operand1/2 in;
//                     Result1 (low/quotient), Result2 (high/remainder),
//                     Busy (stall request) out
// Revision : 1.0 - initial release
// ============================================================================
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input wire logic     CLK,
    input wire logic     Reset_n,
    mcycle_unit_if.slave bus
);
    import mcycle_pkg::*;

    localparam int                 C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   C_ONE   = WIDTH'(1);

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_q;    // negate product / quotient
    logic               r_neg_r;    // negate remainder
    logic               r_div0;
    logic [WIDTH-1:0]   r_op1_raw;
    logic [WIDTH-1:0]   r_res1;
    logic [WIDTH-1:0]   r_res2;

    logic               w_start;
    logic               w_signed;
    logic               w_div;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_dp_hi;
    logic [WIDTH-1:0]   w_dp_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fin1;
    logic [WIDTH-1:0]   w_fin2;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic en);
        return (en && x[WIDTH-1]) ? (~x + C_ONE) : x;
    endfunction

    assign w_start  = (r_state == IDLE) && bus.Start;
    assign w_signed = (bus.MCycleOp == OP_SMUL) || (bus.MCycleOp == OP_SDIV);
    assign w_div    = (bus.MCycleOp == OP_SDIV) || (bus.MCycleOp == OP_UDIV);
    assign w_mag1   = mag(bus.Operand1, w_signed);
    assign w_mag2   = mag(bus.Operand2, w_signed);

    mcycle_iter_dp #(
        .WIDTH    (WIDTH)
    ) u_dp (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .i_load   (w_start),
        .i_step   (r_state == COMPUTE),
        .i_is_div (r_is_div),
        .i_ld_lo  (w_div ? w_mag1 : w_mag2),
        .i_ld_b   (w_div ? w_mag2 : w_mag1),
        .o_hi     (w_dp_hi),
        .o_lo     (w_dp_lo)
    );

    // Sign correction and divide-by-zero override on the settled datapath.
    always_comb begin
        w_prod = {w_dp_hi, w_dp_lo};
        if (r_neg_q) begin
            w_prod = ~w_prod + (2*WIDTH)'(1);
        end
        if (r_is_div) begin
            if (r_div0) begin
                w_fin1 = '1;
                w_fin2 = r_op1_raw;
            end else begin
                w_fin1 = r_neg_q ? (~w_dp_lo + C_ONE) : w_dp_lo;
                w_fin2 = r_neg_r ? (~w_dp_hi + C_ONE) : w_dp_hi;
            end
        end else begin
            w_fin1 = w_prod[WIDTH-1:0];
            w_fin2 = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_op1_raw <= '0;
            r_res1    <= '0;
            r_res2    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.Start) begin
                        r_is_div  <= w_div;
                        r_neg_q   <= w_signed &&
                                     (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
                        r_neg_r   <= w_signed && bus.Operand1[WIDTH-1];
                        r_div0    <= (bus.Operand2 == '0);
                        r_op1_raw <= bus.Operand1;
                        r_cnt     <= '0;
                        r_state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Start is deliberately not looked at here: the stalled
                    // instruction is still on the bus and must not retrigger.
                    r_res1  <= w_fin1;
                    r_res2  <= w_fin2;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Results must already be valid during DONE, so that cycle shows the
    // corrected values directly; the registers hold them from then on.
    assign bus.Result1 = (r_state == DONE) ? w_fin1 : r_res1;
    assign bus.Result2 = (r_state == DONE) ? w_fin2 : r_res2;

    // Combinational from Start so the PC holds in the decode cycle itself.
    assign bus.Busy = Reset_n && (w_start || (r_state == COMPUTE));

endmodule
`default_nettype wire

// File: tb/tb_mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcycle_unit
// Purpose  : Directed self-checking bench for mcycle_unit (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int WIDTH = 32;

    logic CLK = 1'b0;
    logic Reset_n;

    always #5 CLK = ~CLK;

    mcycle_unit_if #(.WIDTH(WIDTH)) bus ();

    mcycle_unit #(
        .WIDTH   (WIDTH)
    ) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        bus.Start    = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
    endtask

    // Counts cycles with Busy high (bounded); returns positioned in DONE.
    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        #1;
        while (bus.Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
            #1;
        end
        check_eq({tag, " busy_len"}, 64'(n), 64'd33);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
        @(negedge CLK);
        #1;
        start_op(op, a, b);
        wait_busy(tag);
        check_eq({tag, " r1"}, 64'(bus.Result1), 64'(e1));
        check_eq({tag, " r2"}, 64'(bus.Result2), 64'(e2));
        bus.Start = 1'b0;
        @(negedge CLK);
        #1;
        check_eq({tag, " idle_busy"}, 64'(bus.Busy), 64'd0);
        check_eq({tag, " hold_r1"}, 64'(bus.Result1), 64'(e1));
    endtask

    initial begin
        Reset_n      = 1'b0;
        bus.Start    = 1'b0;
        bus.MCycleOp = OP_SMUL;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        #12;
        check_eq("reset busy", 64'(bus.Busy), 64'd0);
        check_eq("reset r1", 64'(bus.Result1), 64'd0);
        check_eq("reset r2", 64'(bus.Result2), 64'd0);
        @(negedge CLK);
        Reset_n = 1'b1;

        run_op("smul 7x6",    OP_SMUL, 32'd7,          32'd6,          32'd42,         32'd0);
        run_op("smul -3x5",   OP_SMUL, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   32'hFFFFFFFF);
        run_op("umul max x2", OP_UMUL, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'h00000001);
        run_op("sdiv -7/2",   OP_SDIV, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);
        run_op("udiv 100/7",  OP_UDIV, 32'd100,        32'd7,          32'd14,         32'd2);
        run_op("sdiv min/-1", OP_SDIV, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);
        run_op("udiv 10/0",   OP_UDIV, 32'd10,         32'd0,          32'hFFFFFFFF,   32'd10);
        run_op("sdiv -10/0",  OP_SDIV, 32'hFFFFFFF6,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF6);

        // Asynchronous reset in the middle of COMPUTE.
        @(negedge CLK);
        #1;
        start_op(OP_UMUL, 32'd7, 32'd9);
        repeat (11) @(negedge CLK);
        #1;
        check_eq("pre-reset busy", 64'(bus.Busy), 64'd1);
        Reset_n      = 1'b0;
        bus.Operand1 = 32'd3;
        bus.Operand2 = 32'd4;
        #1;
        check_eq("midreset busy", 64'(bus.Busy), 64'd0);
        check_eq("midreset r1", 64'(bus.Result1), 64'd0);
        check_eq("midreset r2", 64'(bus.Result2), 64'd0);
        @(negedge CLK);
        #1;
        Reset_n = 1'b1;
        wait_busy("post-reset umul 3x4");
        check_eq("post-reset r1", 64'(bus.Result1), 64'd12);
        check_eq("post-reset r2", 64'(bus.Result2), 64'd0);
        bus.Start = 1'b0;

        // Back-to-back: Start stays high through DONE, next op begins in IDLE.
        @(negedge CLK);
        #1;
        start_op(OP_UMUL, 32'd2, 32'd3);
        wait_busy("b2b umul");
        check_eq("b2b umul r1", 64'(bus.Result1), 64'd6);
        check_eq("b2b umul r2", 64'(bus.Result2), 64'd0);
        start_op(OP_UDIV, 32'd9, 32'd3);
        @(negedge CLK);
        #1;
        check_eq("b2b idle busy", 64'(bus.Busy), 64'd1);
        check_eq("b2b idle hold", 64'(bus.Result1), 64'd6);
        wait_busy("b2b udiv");
        check_eq("b2b udiv r1", 64'(bus.Result1), 64'd3);
        check_eq("b2b udiv r2", 64'(bus.Result2), 64'd0);
        bus.Start = 1'b0;
        @(negedge CLK);
        #1;
        check_eq("b2b end busy", 64'(bus.Busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
